fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the instruction decoder.
- Fetches 32-bit instruction words over the core memory bus.
- Buffers them with their PC in a small FIFO.
- Presents {pc, instruction} to the decode stage with a valid/ready handshake.
- Handles control-flow redirects (jump, taken branch, trap, mret) by flushing and refetching.

---
 rtl/fetch_unit_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types for the fetch stage: machine word and the {pc, instr} pair
// carried from the bus to the decoder.
package fetch_unit_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t pc;
        word_t instr;
    } fetch_entry_t;

    // Redirect targets may carry junk in the byte-offset bits.
    function automatic word_t align_word(input word_t addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush, exposing its occupancy and head entry.
// Generic over element type so it can back other buffers in the core.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter type T = fetch_entry_t,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  T              push_data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [CW-1:0] count_o,
    output T              head_o
);

    T              mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    // Flush wins over both push and pop in the same cycle.
    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && !flush_i && (count_q != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word fetches on the memory bus, buffers
// {pc, instr} for decode and flushes/refetches on control-flow redirects.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter word_t       RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic  clk,
    input  logic  reset,
    output logic  mem_valid,
    output word_t mem_address,
    input  logic  mem_ready,
    input  word_t mem_rdata,
    output logic  out_valid,
    input  logic  out_ready,
    output word_t out_data,
    output word_t out_pc,
    input  logic  redirect_valid,
    input  word_t redirect_pc
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    fetch_state_t  state_q, state_d;
    word_t         fetch_pc_q, fetch_pc_d;
    word_t         mem_address_q, mem_address_d;
    logic          mem_valid_q, mem_valid_d;

    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;
    logic          push;
    logic          pop;
    logic          room;
    word_t         redir_pc;
    word_t         next_seq_pc;

    assign redir_pc    = align_word(redirect_pc);
    assign next_seq_pc = mem_address_q + 32'd4;

    assign out_valid  = (count != '0) && !redirect_valid;
    assign pop        = out_valid && out_ready;
    assign push       = (state_q == REQ) && mem_ready && !redirect_valid;
    assign push_entry = '{pc: mem_address_q, instr: mem_rdata};

    // Occupancy after this cycle's push/pop; a new request needs a free slot
    // beyond that, and at most one request is ever outstanding.
    assign count_next = count + CW'(push) - CW'(pop);
    assign room       = count_next < CW'(DEPTH);

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        mem_address_d = mem_address_q;
        unique case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    fetch_pc_d    = redir_pc;
                    mem_address_d = redir_pc;
                    state_d       = REQ;
                end else if (room) begin
                    mem_address_d = fetch_pc_q;
                    state_d       = REQ;
                end
            end
            REQ: begin
                if (redirect_valid) begin
                    fetch_pc_d = redir_pc;
                    if (mem_ready) begin
                        mem_address_d = redir_pc;
                    end else begin
                        state_d = DISCARD;
                    end
                end else if (mem_ready) begin
                    fetch_pc_d = next_seq_pc;
                    if (room) begin
                        mem_address_d = next_seq_pc;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DISCARD: begin
                // The stale request must still complete before retargeting.
                if (redirect_valid) begin
                    fetch_pc_d = redir_pc;
                end
                if (mem_ready) begin
                    mem_address_d = redirect_valid ? redir_pc : fetch_pc_q;
                    state_d       = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        mem_valid_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            fetch_pc_q    <= RESET_PC;
            mem_address_q <= RESET_PC;
            mem_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            mem_address_q <= mem_address_d;
            mem_valid_q   <= mem_valid_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_fifo (
        .clk_i       (clk),
        .rst_ni      (reset),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .count_o     (count),
        .head_o      (head)
    );

    assign mem_valid   = mem_valid_q;
    assign mem_address = mem_address_q;
    assign out_data    = head.instr;
    assign out_pc      = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed timeline checks plus a randomized phase
// scored against an in-order PC-stream model of what decode must receive.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        mem_valid;
    logic [31:0] mem_address;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [31:0] out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int total = 0;
    int bad   = 0;
    int delivered = 0;

    fetch_unit #(
        .RESET_PC (RST_PC),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_valid      (mem_valid),
        .mem_address    (mem_address),
        .mem_ready      (mem_ready),
        .mem_rdata      (mem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    assign mem_rdata = mem_ready ? memfn(mem_address) : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    // Reference model: decode must see consecutive words starting at the
    // last redirect target (or the reset PC), each with its memory contents.
    logic [31:0] exp_pc;
    logic        stall_pend;
    logic [31:0] stall_addr;

    always @(negedge clk) begin
        if (!reset) begin
            exp_pc     = RST_PC;
            stall_pend = 1'b0;
        end else begin
            if (mem_valid) check("addr_align", {30'd0, mem_address[1:0]}, 32'd0);
            if (stall_pend) begin
                check("bus_hold_valid", {31'd0, mem_valid}, 32'd1);
                check("bus_hold_addr", mem_address, stall_addr);
            end
            if (redirect_valid) begin
                check("redirect_no_out", {31'd0, out_valid}, 32'd0);
                exp_pc = redirect_pc & ~32'h3;
            end else if (out_valid && out_ready) begin
                check("sb_pc", out_pc, exp_pc);
                check("sb_data", out_data, memfn(exp_pc));
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            stall_pend = mem_valid && !mem_ready;
            stall_addr = mem_address;
        end
    end

    initial begin
        int d0;
        reset = 1'b1; mem_ready = 1'b1; out_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0;
        #1 reset = 1'b0;
        #1;
        check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mem_addr", mem_address, RST_PC);

        // Streaming with both sides always ready.
        cyc(); cyc(); reset = 1'b1;
        cyc(); #1;
        check("s_first_valid", {31'd0, mem_valid}, 32'd1);
        check("s_addr0", mem_address, 32'h0);
        check("s_no_out_yet", {31'd0, out_valid}, 32'd0);
        cyc(); #1;
        check("s_addr4", mem_address, 32'h4);
        check("s_out_pc0", out_pc, 32'h0);
        check("s_out_data0", out_data, memfn(32'h0));
        cyc(); #1;
        check("s_addr8", mem_address, 32'h8);
        check("s_out_pc4", out_pc, 32'h4);
        cyc(); #1;
        check("s_addrC", mem_address, 32'hC);
        check("s_out_pc8", out_pc, 32'h8);
        check("s_still_valid", {31'd0, mem_valid}, 32'd1);

        // Decode stalled: FIFO fills to DEPTH and fetching stops.
        out_ready = 1'b0;
        do_reset();
        cyc(); #1;
        check("f_addr0", mem_address, 32'h0);
        cyc(); #1;
        check("f_addr4", mem_address, 32'h4);
        cyc(); #1;
        check("f_full_idle", {31'd0, mem_valid}, 32'd0);
        check("f_head0", out_pc, 32'h0);
        cyc(); #1;
        check("f_still_idle", {31'd0, mem_valid}, 32'd0);
        check("f_out_valid", {31'd0, out_valid}, 32'd1);
        cyc(); out_ready = 1'b1; #1;
        check("f_pop_pc0", out_pc, 32'h0);
        cyc(); #1;
        check("f_pop_pc4", out_pc, 32'h4);
        check("f_resume_valid", {31'd0, mem_valid}, 32'd1);
        check("f_resume_addr8", mem_address, 32'h8);
        cyc(); #1;
        check("f_next_pc8", out_pc, 32'h8);

        // Bus wait states: request must hold steady.
        mem_ready = 1'b0;
        do_reset();
        cyc(); #1;
        check("w_valid", {31'd0, mem_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            cyc(); #1;
            check("w_hold_valid", {31'd0, mem_valid}, 32'd1);
            check("w_hold_addr", mem_address, 32'h0);
            check("w_no_out", {31'd0, out_valid}, 32'd0);
        end
        cyc(); mem_ready = 1'b1; #1;
        cyc(); #1;
        check("w_out_pc0", out_pc, 32'h0);
        check("w_addr4", mem_address, 32'h4);

        // Redirect while the 0x8 request is waiting on the bus.
        do_reset();
        cyc(); cyc(); cyc();
        redirect_valid = 1'b1; redirect_pc = 32'h100; mem_ready = 1'b0; #1;
        check("d_pending_addr8", mem_address, 32'h8);
        check("d_redir_out", {31'd0, out_valid}, 32'd0);
        cyc(); redirect_valid = 1'b0; #1;
        check("d_stale_valid", {31'd0, mem_valid}, 32'd1);
        check("d_stale_addr", mem_address, 32'h8);
        check("d_flushed", {31'd0, out_valid}, 32'd0);
        cyc(); mem_ready = 1'b1; #1;
        check("d_still_stale", mem_address, 32'h8);
        cyc(); #1;
        check("d_new_addr", mem_address, 32'h100);
        check("d_dropped", {31'd0, out_valid}, 32'd0);
        cyc(); #1;
        check("d_first_out", {31'd0, out_valid}, 32'd1);
        check("d_first_pc", out_pc, 32'h100);
        check("d_first_data", out_data, memfn(32'h100));

        // Redirect coinciding with bus completion; target is unaligned.
        redirect_valid = 1'b1; redirect_pc = 32'h203; #1;
        check("r_out_blocked", {31'd0, out_valid}, 32'd0);
        cyc(); redirect_valid = 1'b0; mem_ready = 1'b0; #1;
        check("r_addr200", mem_address, 32'h200);
        check("r_valid", {31'd0, mem_valid}, 32'd1);
        check("r_empty", {31'd0, out_valid}, 32'd0);
        cyc(); mem_ready = 1'b1; #1;
        cyc(); #1;
        check("r_out_pc200", out_pc, 32'h200);
        check("r_addr204", mem_address, 32'h204);

        // PC increment wraps at the top of the address space.
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8; #1;
        cyc(); redirect_valid = 1'b0; #1;
        check("x_addr_fff8", mem_address, 32'hFFFF_FFF8);
        cyc(); #1;
        check("x_addr_fffc", mem_address, 32'hFFFF_FFFC);
        check("x_pc_fff8", out_pc, 32'hFFFF_FFF8);
        cyc(); #1;
        check("x_addr_wrap", mem_address, 32'h0);
        check("x_pc_fffc", out_pc, 32'hFFFF_FFFC);
        cyc(); #1;
        check("x_addr4", mem_address, 32'h4);
        check("x_pc_wrap", out_pc, 32'h0);

        // Asynchronous reset in the middle of a request.
        cyc(); cyc(); #1;
        reset = 1'b0; #1;
        check("a_mem_valid", {31'd0, mem_valid}, 32'd0);
        check("a_out_valid", {31'd0, out_valid}, 32'd0);
        check("a_addr", mem_address, RST_PC);
        cyc(); cyc(); reset = 1'b1;
        cyc(); #1;
        check("a_refetch_valid", {31'd0, mem_valid}, 32'd1);
        check("a_refetch_addr", mem_address, RST_PC);
        check("a_no_stale", {31'd0, out_valid}, 32'd0);

        // Randomized traffic checked by the stream model.
        d0 = delivered;
        for (int i = 0; i < 2000; i++) begin
            cyc();
            mem_ready      = ($urandom_range(0, 9) < 7);
            out_ready      = ($urandom_range(0, 9) < 6);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                                         : $urandom();
        end
        cyc();
        redirect_valid = 1'b0;
        cyc(); #1;
        check("rand_progress", {31'd0, (delivered - d0) > 200}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
